// File: rtl/z80_int_controller_pkg.sv
// z80_int_controller_pkg: register map, FSM states and spurious id shared by the interrupt controller
package z80_int_controller_pkg;
   localparam logic [1:0] REG_MASK  = 2'd0;
   localparam logic [1:0] REG_PEND  = 2'd1;
   localparam logic [1:0] REG_VBASE = 2'd2;
   localparam logic [1:0] REG_ISR   = 2'd3;
   localparam logic [2:0] SPUR_ID   = 3'b111;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_e;
endpackage

// File: rtl/z80_int_controller_prio_enc.sv
// z80_int_controller_prio_enc: lowest-index-first priority encoder with valid flag
module z80_int_controller_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] req_i,
   output logic [2:0]   idx_o,
   output logic         vld_o
);
   // scan downwards so the lowest set index is the one left standing
   always_comb begin
      idx_o = 3'd0;
      vld_o = |req_i;
      for (int i = N - 1; i >= 0; i--)
         if (req_i[i]) idx_o = 3'(i);
   end
endmodule

// File: rtl/z80_int_controller.sv
// z80_int_controller: IM2 vectored interrupt controller with fixed priority and nesting
module z80_int_controller
   import z80_int_controller_pkg::*;
#(
   parameter int N_IRQ       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_cs_n,
   input  logic             i_rd_n,
   input  logic             i_wr_n,
   input  logic [1:0]       i_addr,
   input  logic [7:0]       i_data,
   output logic [7:0]       o_data,
   input  logic             i_m1_n,
   input  logic             i_iorq_n,
   input  logic [N_IRQ-1:0] i_irq,
   output logic             o_int,
   output logic [7:0]       o_vec,
   output logic             o_vec_oe
);
   logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [N_IRQ-1:0] mask_q, isr_q, isr_d, pend;
   logic [3:0]       vbase_q;
   logic [2:0]       id_q, id_d, win_idx, top_idx;
   logic             win_v, top_v, eligible, inta, wr_act, wr_q, we, eoi, ack_set, rd_unused;
   state_e           state_q, state_d;

   // reads are combinational on the address, so the read strobe carries no information here
   assign rd_unused = i_rd_n;
   assign pend      = sync_q[SYNC_STAGES-1] & mask_q;
   assign inta      = ~i_m1_n & ~i_iorq_n;
   assign wr_act    = ~i_cs_n & ~i_wr_n;
   assign we        = wr_act & ~wr_q;
   assign eoi       = we & (i_addr == REG_ISR);
   assign eligible  = win_v & (~top_v | (win_idx < top_idx));
   assign o_int     = state_q == S_REQ;
   assign o_vec_oe  = state_q == S_ACK;
   assign o_vec     = {vbase_q, id_q, 1'b0};

   z80_int_controller_prio_enc #(.N(N_IRQ)) u_win (.req_i(pend),  .idx_o(win_idx), .vld_o(win_v));
   z80_int_controller_prio_enc #(.N(N_IRQ)) u_top (.req_i(isr_q), .idx_o(top_idx), .vld_o(top_v));

   // bring the asynchronous request levels into the clock domain
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n)
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      else begin
         sync_q[0] <= i_irq;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end

   // request -> acknowledge sequencing; the id is latched at INTA and frozen for the whole ACK
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ack_set = 1'b0;
      unique case (state_q)
         S_IDLE: state_d = eligible ? S_REQ : S_IDLE;
         S_REQ:
            if (inta) begin
               state_d = S_ACK;
               id_d    = eligible ? win_idx : SPUR_ID;
               ack_set = eligible;
            end else if (!eligible) state_d = S_IDLE;
         S_ACK:  state_d = inta ? S_ACK : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // EOI retires the highest-priority in-service bit before the new acknowledge sets its own
   always_comb begin
      isr_d = isr_q;
      if (eoi && top_v) isr_d[top_idx] = 1'b0;
      if (ack_set) isr_d[win_idx] = 1'b1;
   end

   // register file, write edge detect and FSM state
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         id_q    <= 3'd0;
         mask_q  <= '0;
         vbase_q <= 4'd0;
         isr_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         isr_q   <= isr_d;
         wr_q    <= wr_act;
         if (we && i_addr == REG_MASK)  mask_q  <= i_data[N_IRQ-1:0];
         if (we && i_addr == REG_VBASE) vbase_q <= i_data[7:4];
      end

   // read mux
   always_comb
      o_data = i_addr == REG_MASK  ? 8'(mask_q) :
               i_addr == REG_PEND  ? 8'(pend)   :
               i_addr == REG_VBASE ? {vbase_q, 4'h0} : 8'(isr_q);
endmodule

// File: tb/tb_z80_int_controller.sv
// tb_z80_int_controller: directed + random checks of the IM2 controller against a priority model
module tb_z80_int_controller;
   logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1, iorq_n = 1'b1;
   logic [1:0] addr = 2'd0;
   logic [7:0] data = 8'd0, irq = 8'd0;
   logic [7:0] o_data, o_vec;
   logic       o_int, o_vec_oe;
   int         n_cmp = 0, n_bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] m_mask = 8'd0, m_vbase = 8'd0, m_isr = 8'd0, m_irq = 8'd0;

   z80_int_controller dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_cs_n(cs_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
      .i_addr(addr), .i_data(data), .o_data(o_data), .i_m1_n(m1_n), .i_iorq_n(iorq_n),
      .i_irq(irq), .o_int(o_int), .o_vec(o_vec), .o_vec_oe(o_vec_oe)
   );

   always #5 clk = ~clk;

   function automatic int lowest(logic [7:0] x);
      for (int i = 0; i < 8; i++) if (x[i]) return i;
      return 8;
   endfunction

   function automatic bit m_elig();
      logic [7:0] p = m_irq & m_mask;
      return p != 0 && lowest(p) < lowest(m_isr);
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic wr(logic [1:0] a, logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; addr = a; data = d;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      if (a == 2'd0) m_mask = d;
      if (a == 2'd2) m_vbase = d & 8'hF0;
      if (a == 2'd3 && m_isr != 0) m_isr[lowest(m_isr)] = 1'b0;
   endtask

   task automatic rd(logic [1:0] a, string name);
      logic [7:0] e;
      @(negedge clk);
      addr = a; cs_n = 1'b0; rd_n = 1'b0;
      #1;
      e = a == 2'd0 ? m_mask : a == 2'd1 ? (m_irq & m_mask) : a == 2'd2 ? m_vbase : m_isr;
      check(name, o_data, e);
      cs_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic settle();
      repeat (5) @(negedge clk);
   endtask

   task automatic chk_int(string name);
      check(name, 8'(o_int), 8'(m_elig()));
   endtask

   task automatic set_irq(logic [7:0] v);
      @(negedge clk);
      irq = v; m_irq = v;
   endtask

   // acknowledge a pending request; the expected vector goes to the scoreboard
   task automatic do_inta();
      logic [2:0] id = 3'b111;
      if (m_elig()) begin
         id = 3'(lowest(m_irq & m_mask));
         m_isr[id] = 1'b1;
      end
      exp_q.push_back({m_vbase[7:4], id, 1'b0});
      @(negedge clk);
      m1_n = 1'b0; iorq_n = 1'b0;
      repeat (2) @(negedge clk);
      check("oe_in_ack", 8'(o_vec_oe), 8'd1);
      m1_n = 1'b1; iorq_n = 1'b1;
      @(negedge clk);
      check("oe_after_ack", 8'(o_vec_oe), 8'd0);
   endtask

   // monitor: every rising o_vec_oe must match the oldest expected vector
   initial begin
      logic prev = 1'b0;
      forever begin
         @(negedge clk);
         if (o_vec_oe && !prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_ack: vector %02h presented, none expected", o_vec);
            end else check("vector", o_vec, exp_q.pop_front());
         end
         prev = o_vec_oe;
      end
   end

   initial begin
      irq = 8'hFF; m_irq = 8'hFF;
      repeat (3) @(negedge clk);
      check("rst_int", 8'(o_int), 8'd0);
      check("rst_oe", 8'(o_vec_oe), 8'd0);
      rst_n = 1'b1;
      rd(2'd0, "rst_mask"); rd(2'd1, "rst_pend"); rd(2'd2, "rst_vbase"); rd(2'd3, "rst_isr");
      settle();
      chk_int("masked_all");

      set_irq(8'h00);
      wr(2'd0, 8'h04); wr(2'd2, 8'hA5);
      settle();
      rd(2'd2, "vbase_low_zero");
      @(negedge clk);
      irq = 8'h04; m_irq = 8'h04;
      repeat (2) @(negedge clk);
      check("latency_early", 8'(o_int), 8'd0);
      @(negedge clk);
      check("latency_hit", 8'(o_int), 8'd1);
      do_inta();
      rd(2'd3, "isr_after_ack");

      wr(2'd0, 8'hFF);
      set_irq(8'h24);
      settle(); chk_int("nest_lower_blocked");
      set_irq(8'h26);
      settle(); chk_int("nest_higher_int");
      do_inta();
      rd(2'd3, "isr_nested");
      set_irq(8'h24);
      wr(2'd3, 8'h00);
      rd(2'd3, "isr_after_eoi");
      settle(); chk_int("after_eoi_int");
      set_irq(8'h00);
      wr(2'd3, 8'h00);
      rd(2'd3, "isr_cleared");
      wr(2'd3, 8'h00);
      rd(2'd3, "eoi_noop");

      wr(2'd0, 8'h04);
      set_irq(8'h04);
      settle(); chk_int("req_up");
      set_irq(8'h00);
      settle(); chk_int("req_dropped");
      set_irq(8'h04);
      settle(); chk_int("req_again");
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; addr = 2'd0; data = 8'h00;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1; m1_n = 1'b0; iorq_n = 1'b0;
      m_mask = 8'h00;
      exp_q.push_back({m_vbase[7:4], 3'b111, 1'b0});
      repeat (2) @(negedge clk);
      m1_n = 1'b1; iorq_n = 1'b1;
      rd(2'd3, "isr_after_spurious");
      settle(); chk_int("idle_after_spurious");

      wr(2'd0, 8'hFF);
      set_irq(8'h48);
      settle(); chk_int("two_src_int");
      do_inta();
      set_irq(8'h40);
      wr(2'd3, 8'h00);
      settle(); chk_int("second_src_int");
      do_inta();
      rd(2'd3, "isr_second");
      set_irq(8'h00);
      wr(2'd3, 8'h00);

      for (int k = 0; k < 40; k++) begin
         logic [7:0] r = 8'($urandom);
         if (r[0]) wr(2'd0, 8'($urandom));
         if (r[1] && r[2]) wr(2'd2, 8'($urandom));
         if (r[3]) wr(2'd3, 8'($urandom));
         set_irq(8'($urandom & $urandom));
         settle();
         chk_int("rand_int");
         if (m_elig()) do_inta();
         if (r[4]) rd(2'd3, "rand_isr");
         if (r[5]) rd(2'd1, "rand_pend");
      end

      set_irq(8'h00);
      for (int k = 0; k < 8; k++) wr(2'd3, 8'h00);
      wr(2'd0, 8'hFF);
      set_irq(8'h01);
      settle(); chk_int("pre_reset_int");
      exp_q.push_back({m_vbase[7:4], 3'd0, 1'b0});
      @(negedge clk);
      m1_n = 1'b0; iorq_n = 1'b0;
      @(negedge clk);
      check("oe_before_reset", 8'(o_vec_oe), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_oe", 8'(o_vec_oe), 8'd0);
      check("reset_int", 8'(o_int), 8'd0);
      m1_n = 1'b1; iorq_n = 1'b1; irq = 8'h00;
      m_mask = 8'h00; m_vbase = 8'h00; m_isr = 8'h00; m_irq = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      rd(2'd0, "post_rst_mask"); rd(2'd2, "post_rst_vbase"); rd(2'd3, "post_rst_isr");
      settle();
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
